// File: rtl/fifo_umbral.sv
// Synchronous FIFO with programmable almost-full/almost-empty thresholds and error flag.
// Define FIFO_ERR_STICKY_EN to make error_out latch until reset instead of pulsing.
module fifo_umbral #(
   parameter int unsigned DATA_WIDTH = 6,
   parameter int unsigned ADDR_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic                  pop,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [ADDR_WIDTH:0]   umbral_alto,
   input  logic [ADDR_WIDTH:0]   umbral_bajo,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  valid_out,
   output logic                  fifo_full,
   output logic                  fifo_empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  error_out
);

   localparam logic [ADDR_WIDTH:0] Depth = {1'b1, {ADDR_WIDTH{1'b0}}};

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
   logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  valid_q;
   logic                  error_q, error_d;
   logic                  push_ok, pop_ok, violation;

   // Acceptance uses the flags as they stand before the edge, so a push into a
   // slot freed by a same-cycle pop is still rejected.
   always_comb begin
      push_ok   = push && !fifo_full;
      pop_ok    = pop && !fifo_empty;
      violation = (push && fifo_full) || (pop && fifo_empty);
      count_d   = count_q;
      if (push_ok && !pop_ok) begin
         count_d = count_q + 1'b1;
      end else if (pop_ok && !push_ok) begin
         count_d = count_q - 1'b1;
      end
`ifdef FIFO_ERR_STICKY_EN
      error_d = error_q | violation;
`else
      error_d = violation;
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         valid_q <= pop_ok;
         error_q <= error_d;
         if (push_ok) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
            data_q   <= mem[rd_ptr_q];
         end
      end
   end

   // Storage is intentionally not reset.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr_q] <= data_in;
      end
   end

   always_comb begin
      count        = count_q;
      data_out     = data_q;
      valid_out    = valid_q;
      error_out    = error_q;
      fifo_full    = (count_q == Depth);
      fifo_empty   = (count_q == '0);
      almost_full  = (umbral_alto == '0) || (count_q >= umbral_alto);
      almost_empty = (umbral_bajo >= Depth) || (count_q <= umbral_bajo);
   end

endmodule

// File: doc/fifo_umbral.md
# fifo_umbral

Synchronous FIFO with programmable almost-full/almost-empty thresholds and overflow/underflow error detection. It sits directly upstream of the flow-control state machine and produces the FIFO status the machine consumes: full, empty, threshold crossings, and error. Write and read requests come from the transaction layer. Data leaves through a registered read port.

## Interface
- DATA_WIDTH, 6: word width in bits.
- ADDR_WIDTH, 3: pointer width; depth = 2**ADDR_WIDTH (8).

- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset; the block is held in reset while low.
- push  in  1  write request; data_in is sampled on the same edge.
- pop  in  1  read request.
- data_in  in  DATA_WIDTH  write data.
- umbral_alto  in  ADDR_WIDTH+1  almost-full threshold, in words.
- umbral_bajo  in  ADDR_WIDTH+1  almost-empty threshold, in words.
- data_out  out  DATA_WIDTH  registered read data.
- valid_out  out  1  data_out was updated by an accepted pop.
- fifo_full  out  1  count == depth.
- fifo_empty  out  1  count == 0.
- almost_full  out  1  count >= umbral_alto.
- almost_empty  out  1  count <= umbral_bajo.
- count  out  ADDR_WIDTH+1  current occupancy, 0..depth.
- error_out  out  1  overflow or underflow attempt.

## Operation
- Storage: 2**ADDR_WIDTH x DATA_WIDTH register array.
  - wr_ptr and rd_ptr are ADDR_WIDTH bits and wrap modulo depth.
  - count is tracked separately.
- Push accepted iff push && !fifo_full.
  - Writes mem[wr_ptr] <= data_in and increments wr_ptr.
- Pop accepted iff pop && !fifo_empty.
  - Loads data_out <= mem[rd_ptr], increments rd_ptr, and pulses valid_out for one cycle.
- Accepted push and accepted pop in the same cycle: both execute and count is unchanged.
- count update: +1 for push only, -1 for pop only, else hold.
- Push while full is rejected regardless of pop:
  - no write; wr_ptr and count unaffected by the push;
  - error condition raised;
  - a simultaneous pop is still accepted.
- Pop while empty is rejected regardless of push:
  - data_out holds and valid_out = 0;
  - error condition raised;
  - a simultaneous push is still accepted, so there is no fall-through.
- data_out holds its last value whenever no pop is accepted.
- Flags are combinational from the registered count and the current threshold inputs. Thresholds may change at any time and take effect immediately.
- Threshold edge cases:
  - umbral_alto = 0 forces almost_full = 1.
  - umbral_bajo >= depth forces almost_empty = 1.
- Reset values (reset low, asynchronous): pointers 0, count 0, fifo_empty 1, fifo_full 0, almost_empty 1, almost_full = (umbral_alto == 0), data_out 0, valid_out 0, error_out 0. Memory contents are not reset.
- Reset asserted mid-operation discards all stored words. The first pop after release with no push is an underflow.

## Timing
- Write-to-flag latency: count and all flags reflect a push or pop on the cycle after the edge that accepts it.
- Read latency: data_out and valid_out are valid one cycle after the edge that accepts the pop.
- Full-to-accept: a push in the same cycle as the pop that frees a slot is still rejected, because full is evaluated before the edge. The next cycle's push is accepted.
- error_out is registered and asserts on the edge following the offending request.

## Configuration
- FIFO_ERR_STICKY_EN defined: error_out latches at 1 on the first overflow/underflow and clears only on reset.
- FIFO_ERR_STICKY_EN undefined: error_out is a one-cycle pulse per offending cycle. It is high for consecutive cycles if violations are consecutive.

## Test plan
- Reset mid-transfer: push 3 words, drive reset low between edges -> all outputs go to their reset values immediately, with no clock needed; count 0, fifo_empty 1.
- Fill with umbral_alto=6: push 0x01..0x08 on consecutive cycles ->
  - almost_full 1 one cycle after the 6th push;
  - fifo_full 1 after the 8th;
  - a 9th push (0x09) -> error_out 1 the next cycle, count stays 8, and 0x09 is never read.
- Drain with umbral_bajo=2: pop 8 times ->
  - data_out 0x01..0x08 in order, each with valid_out, one cycle after its pop;
  - almost_empty 1 once count reaches 2;
  - fifo_empty 1 after the last pop;
  - a 9th pop -> valid_out 0, data_out holds 0x08, error_out 1.
- Simultaneous push/pop at count 3 (contents 0x0A,0x0B,0x0C), push 0x0D -> data_out 0x0A, count stays 3; then 3 pops yield 0x0B,0x0C,0x0D.
- Pointer wrap: push 5 and pop 5, then push 0x20..0x27 (8 words, wrapping) -> fifo_full 1, and 8 pops return 0x20..0x27 in order.
- Error mode: two underflows 4 cycles apart, then idle ->
  - with FIFO_ERR_STICKY_EN, error_out goes high and stays 1 until reset;
  - without it, error_out shows two single-cycle pulses.
